// File: rtl/frac_div_pkg.sv
// Shared types for the fractional-N divider: MASH order, modulator output width
// and divider FSM states.
package frac_div_pkg;

    typedef enum logic [1:0] {
        ORD_NONE = 2'd0,
        ORD_1    = 2'd1,
        ORD_2    = 2'd2,
        ORD_3    = 2'd3
    } mash_order_e;

    localparam int unsigned Y_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } div_state_e;

endpackage

// File: rtl/frac_n_divider_mash_mash111.sv
// MASH 1-1-1 delta-sigma modulator, advanced once per step strobe.
// Produces a signed period correction y in -3..+4 for the selected order.
module mash111_mod
    import frac_div_pkg::*;
#(
    parameter int unsigned FRAC_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  step_i,
    input  logic                  clear_i,
    input  logic [FRAC_W-1:0]     frac_i,
    input  mash_order_e           order_i,
    output logic signed [Y_W-1:0] y_o
);

    logic [FRAC_W-1:0] acc1_q, acc2_q, acc3_q;
    logic [FRAC_W-1:0] acc1_d, acc2_d, acc3_d;
    logic              c2_z1_q, c3_z1_q, c3_z2_q;
    logic              c2_z1_d, c3_z1_d, c3_z2_d;

    logic [FRAC_W-1:0] a1, a2, a3;
    logic              z2, z3, z33;
    logic [FRAC_W:0]   s1, s2, s3;
    logic              c1, c2, c3;
    logic signed [Y_W-1:0] e1, e2, e3;

    // A clear applied on a step cycle makes this step start from the zeroed state.
    always_comb begin
        a1  = clear_i ? '0   : acc1_q;
        a2  = clear_i ? '0   : acc2_q;
        a3  = clear_i ? '0   : acc3_q;
        z2  = clear_i ? 1'b0 : c2_z1_q;
        z3  = clear_i ? 1'b0 : c3_z1_q;
        z33 = clear_i ? 1'b0 : c3_z2_q;

        s1 = {1'b0, a1} + {1'b0, frac_i};
        s2 = {1'b0, a2} + {1'b0, s1[FRAC_W-1:0]};
        s3 = {1'b0, a3} + {1'b0, s2[FRAC_W-1:0]};
        c1 = s1[FRAC_W];
        c2 = s2[FRAC_W];
        c3 = s3[FRAC_W];

        e1 = $signed({{(Y_W-1){1'b0}}, c1});
        e2 = $signed({{(Y_W-1){1'b0}}, c2}) - $signed({{(Y_W-1){1'b0}}, z2});
        e3 = $signed({{(Y_W-1){1'b0}}, c3})
           - $signed({{(Y_W-2){1'b0}}, z3, 1'b0})
           + $signed({{(Y_W-1){1'b0}}, z33});

        y_o = '0;
        case (order_i)
            ORD_1:   y_o = e1;
            ORD_2:   y_o = e1 + e2;
            ORD_3:   y_o = e1 + e2 + e3;
            default: y_o = '0;
        endcase

        acc1_d  = acc1_q;
        acc2_d  = acc2_q;
        acc3_d  = acc3_q;
        c2_z1_d = c2_z1_q;
        c3_z1_d = c3_z1_q;
        c3_z2_d = c3_z2_q;
        if (step_i) begin
            acc1_d  = s1[FRAC_W-1:0];
            acc2_d  = s2[FRAC_W-1:0];
            acc3_d  = s3[FRAC_W-1:0];
            c2_z1_d = c2;
            c3_z1_d = c3;
            c3_z2_d = z3;
        end else if (clear_i) begin
            acc1_d  = '0;
            acc2_d  = '0;
            acc3_d  = '0;
            c2_z1_d = 1'b0;
            c3_z1_d = 1'b0;
            c3_z2_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc1_q  <= '0;
            acc2_q  <= '0;
            acc3_q  <= '0;
            c2_z1_q <= 1'b0;
            c3_z1_q <= 1'b0;
            c3_z2_q <= 1'b0;
        end else begin
            acc1_q  <= acc1_d;
            acc2_q  <= acc2_d;
            acc3_q  <= acc3_d;
            c2_z1_q <= c2_z1_d;
            c3_z1_q <= c3_z1_d;
            c3_z2_q <= c3_z2_d;
        end
    end

endmodule

// File: rtl/frac_n_divider_mash.sv
// Fractional-N clock divider: period counter, ~50% duty output, config shadow
// with valid/ready handshake, ratio clamping; MASH modulator supplies the dither.
module frac_n_divider_mash
    import frac_div_pkg::*;
#(
    parameter int unsigned INT_W   = 8,
    parameter int unsigned FRAC_W  = 16,
    parameter int unsigned DEF_INT = 8,
    parameter int unsigned MIN_DIV = 2
) (
    input  logic              input_clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [INT_W-1:0]  cfg_int,
    input  logic [FRAC_W-1:0] cfg_frac,
    input  logic [1:0]        cfg_order,
    input  logic              cfg_clear,
    output logic              output_clk,
    output logic              div_pulse,
    output logic [INT_W:0]    cur_ratio,
    output logic              clamp_evt
);

    localparam logic signed [INT_W+1:0] MIN_S   = (INT_W+2)'(MIN_DIV);
    localparam logic [INT_W:0]          MIN_U   = (INT_W+1)'(MIN_DIV);
    localparam logic [INT_W-1:0]        DEF_I   = INT_W'(DEF_INT);
    localparam logic [INT_W:0]          DEF_R   = (INT_W+1)'(DEF_INT);

    div_state_e        state_q, state_d;
    logic [INT_W:0]    cnt_q, cnt_d;
    logic [INT_W:0]    ratio_q, ratio_d;
    logic              oclk_q, oclk_d;
    logic              pulse_q, pulse_d;
    logic              clamp_q, clamp_d;

    logic [INT_W-1:0]  act_int_q, act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    mash_order_e       act_order_q, act_order_d;

    logic              sh_full_q, sh_full_d;
    logic [INT_W-1:0]  sh_int_q, sh_int_d;
    logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
    mash_order_e       sh_order_q, sh_order_d;
    logic              sh_clear_q, sh_clear_d;

    logic              boundary, accept, apply_clear, launch, clamped;
    logic signed [Y_W-1:0]    y;
    logic signed [INT_W+1:0]  n_wide;
    logic [INT_W:0]           n_sat;

    // Config path: a pending shadow wins; otherwise an offer landing on a
    // boundary bypasses the shadow and is used for that same boundary.
    always_comb begin
        boundary    = (state_q == IDLE) || (cnt_q == '0);
        accept      = cfg_valid && !sh_full_q;
        apply_clear = 1'b0;
        sh_full_d   = sh_full_q;
        sh_int_d    = sh_int_q;
        sh_frac_d   = sh_frac_q;
        sh_order_d  = sh_order_q;
        sh_clear_d  = sh_clear_q;
        act_int_d   = act_int_q;
        act_frac_d  = act_frac_q;
        act_order_d = act_order_q;
        if (boundary && sh_full_q) begin
            act_int_d   = sh_int_q;
            act_frac_d  = sh_frac_q;
            act_order_d = sh_order_q;
            apply_clear = sh_clear_q;
            sh_full_d   = 1'b0;
        end else if (boundary && accept) begin
            act_int_d   = cfg_int;
            act_frac_d  = cfg_frac;
            act_order_d = mash_order_e'(cfg_order);
            apply_clear = cfg_clear;
        end else if (accept) begin
            sh_int_d    = cfg_int;
            sh_frac_d   = cfg_frac;
            sh_order_d  = mash_order_e'(cfg_order);
            sh_clear_d  = cfg_clear;
            sh_full_d   = 1'b1;
        end
        launch = boundary && enable;
    end

    mash111_mod #(
        .FRAC_W (FRAC_W)
    ) u_mash (
        .clk_i   (input_clk),
        .rst_ni  (rst_n),
        .step_i  (launch),
        .clear_i (apply_clear),
        .frac_i  (act_frac_d),
        .order_i (act_order_d),
        .y_o     (y)
    );

    always_comb begin
        n_wide  = $signed({2'b00, act_int_d}) + $signed({{(INT_W+2-Y_W){y[Y_W-1]}}, y});
        clamped = (n_wide < MIN_S);
        n_sat   = clamped ? MIN_U : n_wide[INT_W:0];

        state_d = state_q;
        cnt_d   = cnt_q;
        ratio_d = ratio_q;
        pulse_d = 1'b0;
        clamp_d = 1'b0;
        if (boundary) begin
            state_d = enable ? RUN : IDLE;
            if (launch) begin
                cnt_d   = n_sat - 1'b1;
                ratio_d = n_sat;
                pulse_d = 1'b1;
                clamp_d = clamped;
            end
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
        // High for the first ceil(N/2) counts of the period (N-1 down to floor(N/2)).
        oclk_d = (state_d == RUN) && (cnt_d >= (ratio_d >> 1));
    end

    always_ff @(posedge input_clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ratio_q     <= DEF_R;
            oclk_q      <= 1'b0;
            pulse_q     <= 1'b0;
            clamp_q     <= 1'b0;
            act_int_q   <= DEF_I;
            act_frac_q  <= '0;
            act_order_q <= ORD_NONE;
            sh_full_q   <= 1'b0;
            sh_int_q    <= '0;
            sh_frac_q   <= '0;
            sh_order_q  <= ORD_NONE;
            sh_clear_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ratio_q     <= ratio_d;
            oclk_q      <= oclk_d;
            pulse_q     <= pulse_d;
            clamp_q     <= clamp_d;
            act_int_q   <= act_int_d;
            act_frac_q  <= act_frac_d;
            act_order_q <= act_order_d;
            sh_full_q   <= sh_full_d;
            sh_int_q    <= sh_int_d;
            sh_frac_q   <= sh_frac_d;
            sh_order_q  <= sh_order_d;
            sh_clear_q  <= sh_clear_d;
        end
    end

    assign cfg_ready  = !sh_full_q;
    assign output_clk = oclk_q;
    assign div_pulse  = pulse_q;
    assign cur_ratio  = ratio_q;
    assign clamp_evt  = clamp_q;

endmodule

// File: tb/tb_frac_n_divider_mash.sv
// Directed self-checking bench for frac_n_divider_mash; outputs sampled on the
// falling edge, inputs driven on the falling edge.
module tb_frac_n_divider_mash;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [7:0]  cfg_int = '0;
    logic [15:0] cfg_frac = '0;
    logic [1:0]  cfg_order = '0;
    logic        cfg_clear = 1'b0;
    logic        output_clk;
    logic        div_pulse;
    logic [8:0]  cur_ratio;
    logic        clamp_evt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frac_n_divider_mash #(
        .INT_W   (8),
        .FRAC_W  (16),
        .DEF_INT (8),
        .MIN_DIV (2)
    ) dut (
        .input_clk  (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_int    (cfg_int),
        .cfg_frac   (cfg_frac),
        .cfg_order  (cfg_order),
        .cfg_clear  (cfg_clear),
        .output_clk (output_clk),
        .div_pulse  (div_pulse),
        .cur_ratio  (cur_ratio),
        .clamp_evt  (clamp_evt)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Offered while IDLE with ready high, so it takes effect on the next edge.
    task automatic apply_cfg(input int i, input int f, input int o, input bit c);
        cfg_valid = 1'b1; cfg_int = 8'(i); cfg_frac = 16'(f); cfg_order = 2'(o); cfg_clear = c;
        @(negedge clk);
        cfg_valid = 1'b0; cfg_clear = 1'b0;
    endtask

    task automatic wait_pulse(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (div_pulse) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    // Called on the first cycle of a period; returns on the first cycle of the next.
    task automatic measure_period(output int len, output int high, output logic [8:0] ratio,
                                  output logic clmp, output int stray, output bit ok);
        len = 0; high = 0; stray = 0; ok = 1'b0;
        ratio = cur_ratio; clmp = clamp_evt;
        for (int i = 0; i < 600; i++) begin
            len++;
            if (output_clk) high++;
            @(negedge clk);
            if (div_pulse) begin ok = 1'b1; break; end
            if (clamp_evt) stray++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (output_clk !== 1'b0 || div_pulse !== 1'b0 || clamp_evt !== 1'b0 ||
            cfg_ready !== 1'b1 || cur_ratio !== 9'd8) begin
            errors++;
            $display("FAIL reset_state: oclk=%b pulse=%b clamp=%b ready=%b ratio=%0d, want 0 0 0 1 8",
                     output_clk, div_pulse, clamp_evt, cfg_ready, cur_ratio);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (output_clk !== 1'b0 || div_pulse !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: oclk=%b pulse=%b, want 0 0", output_clk, div_pulse);
        end
    endtask

    task automatic test_integer();
        int len, high, stray; logic [8:0] r; logic cl; bit ok;
        do_reset();
        apply_cfg(10, 16'h0000, 3, 1'b0);
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (output_clk !== 1'b1 || div_pulse !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: oclk=%b pulse=%b, want 1 1", output_clk, div_pulse);
        end
        for (int p = 0; p < 8; p++) begin
            measure_period(len, high, r, cl, stray, ok);
            checks++;
            if (!ok || len != 10 || high != 5 || r !== 9'd10 || cl !== 1'b0 || stray != 0) begin
                errors++;
                $display("FAIL int10_period%0d: ok=%0d len=%0d high=%0d ratio=%0d clamp=%b stray=%0d, want 1 10 5 10 0 0",
                         p, ok, len, high, r, cl, stray);
            end
        end
    endtask

    task automatic test_disable();
        int high, pulses;
        enable = 1'b0;
        high = 0; pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (output_clk) high++;
            if (div_pulse) pulses++;
        end
        checks++;
        if (high != 4 || pulses != 0) begin
            errors++;
            $display("FAIL disable_at_boundary: high=%0d pulses=%0d, want 4 0", high, pulses);
        end
    endtask

    task automatic test_mash1();
        int len, high, stray, total; logic [8:0] r; logic cl; bit ok;
        do_reset();
        apply_cfg(10, 16'h8000, 1, 1'b1);
        enable = 1'b1;
        @(negedge clk);
        total = 0;
        for (int p = 0; p < 64; p++) begin
            measure_period(len, high, r, cl, stray, ok);
            total += len;
            checks++;
            if (!ok || len != ((p % 2) ? 11 : 10) || high != (len + 1) / 2 || r !== 9'(len)) begin
                errors++;
                $display("FAIL mash1_period%0d: ok=%0d len=%0d high=%0d ratio=%0d, want len %0d",
                         p, ok, len, high, r, (p % 2) ? 11 : 10);
            end
        end
        checks++;
        if (total != 672) begin
            errors++;
            $display("FAIL mash1_total: got %0d cycles, want 672", total);
        end
    endtask

    task automatic test_mash3();
        int len, high, stray, total, bad; logic [8:0] r; logic cl; bit ok;
        do_reset();
        apply_cfg(20, 16'h4000, 3, 1'b1);
        enable = 1'b1;
        @(negedge clk);
        total = 0;
        for (int p = 0; p < 1024; p++) begin
            measure_period(len, high, r, cl, stray, ok);
            total += len;
            checks++;
            if (!ok || len < 17 || len > 24) begin
                errors++;
                $display("FAIL mash3_period%0d: ok=%0d len=%0d, want 17..24", p, ok, len);
            end
        end
        bad = total - 20736;
        checks++;
        if (bad < -3 || bad > 3) begin
            errors++;
            $display("FAIL mash3_total: got %0d cycles, want 20736 +/-3", total);
        end
    endtask

    task automatic test_clamp();
        int len, high, stray, clamps, s1, s2, s3, a1, a2, a3, c1, c2, c3, z2, z3, z33, y, n;
        logic [8:0] r; logic cl, ecl; bit ok;
        do_reset();
        apply_cfg(2, 16'hFFFF, 3, 1'b1);
        enable = 1'b1;
        @(negedge clk);
        a1 = 0; a2 = 0; a3 = 0; z2 = 0; z3 = 0; z33 = 0; clamps = 0;
        for (int p = 0; p < 2000; p++) begin
            s1 = a1 + 65535; c1 = s1 / 65536; a1 = s1 % 65536;
            s2 = a2 + a1;    c2 = s2 / 65536; a2 = s2 % 65536;
            s3 = a3 + a2;    c3 = s3 / 65536; a3 = s3 % 65536;
            y = c1 + (c2 - z2) + (c3 - 2 * z3 + z33);
            z33 = z3; z3 = c3; z2 = c2;
            n = 2 + y;
            ecl = (n < 2);
            if (ecl) begin n = 2; clamps++; end
            measure_period(len, high, r, cl, stray, ok);
            checks++;
            if (!ok || len != n || r !== 9'(n) || cl !== ecl || stray != 0 || high != (n + 1) / 2) begin
                errors++;
                $display("FAIL clamp_period%0d: ok=%0d len=%0d ratio=%0d clamp=%b stray=%0d high=%0d, want len %0d clamp %b",
                         p, ok, len, r, cl, stray, high, n, ecl);
            end
        end
        $display("clamp scenario: %0d clamped periods expected", clamps);
    endtask

    task automatic test_back_to_back();
        int low, len, high, stray; logic [8:0] r; logic cl; bit ok;
        do_reset();
        apply_cfg(10, 0, 0, 1'b0);
        enable = 1'b1;
        wait_pulse(ok);
        @(negedge clk);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_int = 8'd12; cfg_frac = '0; cfg_order = 2'd0;
        @(negedge clk);
        cfg_valid = 1'b0;
        low = 0;
        for (int n = 0; n < 40; n++) begin
            if (div_pulse) break;
            if (!cfg_ready) low++;
            if (n == 2) begin cfg_valid = 1'b1; cfg_int = 8'd5; end
            else cfg_valid = 1'b0;
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        checks++;
        if (low != 7) begin
            errors++;
            $display("FAIL ready_low_cycles: got %0d, want 7", low);
        end
        checks++;
        if (div_pulse !== 1'b1 || cur_ratio !== 9'd12 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL retune_apply: pulse=%b ratio=%0d ready=%b, want 1 12 1", div_pulse, cur_ratio, cfg_ready);
        end
        measure_period(len, high, r, cl, stray, ok);
        checks++;
        if (!ok || len != 12 || high != 6) begin
            errors++;
            $display("FAIL retune_period: ok=%0d len=%0d high=%0d, want 1 12 6", ok, len, high);
        end
        measure_period(len, high, r, cl, stray, ok);
        checks++;
        if (!ok || len != 12 || r !== 9'd12) begin
            errors++;
            $display("FAIL ignored_cfg: ok=%0d len=%0d ratio=%0d, want 1 12 12", ok, len, r);
        end
    endtask

    task automatic test_mid_reset();
        int pulses; bit ok;
        do_reset();
        apply_cfg(10, 0, 0, 1'b0);
        enable = 1'b1;
        wait_pulse(ok);
        @(negedge clk);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_int = 8'd30;
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (output_clk !== 1'b1 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_state: oclk=%b ready=%b, want 1 0", output_clk, cfg_ready);
        end
        rst_n = 1'b0; enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (output_clk !== 1'b0 || cfg_ready !== 1'b1 || cur_ratio !== 9'd8 || div_pulse !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: oclk=%b ready=%b ratio=%0d pulse=%b, want 0 1 8 0",
                     output_clk, cfg_ready, cur_ratio, div_pulse);
        end
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (div_pulse || output_clk) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL idle_after_reset: %0d active cycles, want 0", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_integer();
        test_disable();
        test_mash1();
        test_mash3();
        test_clamp();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
